// File: rtl/parity_frame_checker.sv
// Column-parity frame checker: XORs FRAME_LEN data nibbles, compares the result with a
// trailing check nibble, and holds the verdict until it is accepted downstream.
//   state    | meaning
//   S_DATA   | accumulating data nibbles of the current frame
//   S_CHECK  | waiting for the check nibble
//   S_RESULT | verdict held on res_* until res_ready
module parity_frame_checker #(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [3:0]       in_nibble,
  output logic             in_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_ok,
  output logic [3:0]       res_syndrome,
  output logic [CNT_W-1:0] err_count,
  input  logic             clr_err
);

  typedef enum logic [1:0] {S_DATA, S_CHECK, S_RESULT} state_t;

  localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

  state_t           state_q, state_d;
  logic [3:0]       acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ok_q, ok_d;
  logic [3:0]       syn_q, syn_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             xfer;
  logic [3:0]       syn_new;

  // Gated with rst_n so nothing is offered as accepted while reset is held.
  assign in_ready     = rst_n && (state_q != S_RESULT);
  assign xfer         = in_valid && in_ready;
  assign res_valid    = (state_q == S_RESULT);
  assign res_ok       = ok_q;
  assign res_syndrome = syn_q;
  assign err_count    = err_q;
  assign syn_new      = acc_q ^ in_nibble;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ok_d    = ok_q;
    syn_d   = syn_q;
    err_d   = err_q;
    unique case (state_q)
      S_DATA: begin
        if (xfer) begin
          acc_d = syn_new;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == LAST_IDX) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (xfer) begin
          syn_d   = syn_new;
          ok_d    = (syn_new == 4'd0);
          state_d = S_RESULT;
          if (syn_new != 4'd0 && err_q != {CNT_W{1'b1}}) err_d = err_q + 1'b1;
        end
      end
      S_RESULT: begin
        if (res_ready) begin
          state_d = S_DATA;
          acc_d   = 4'd0;
          cnt_d   = 8'd0;
        end
      end
      default: state_d = S_DATA;
    endcase
    // Clear takes priority over an increment landing on the same edge.
    if (clr_err) err_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_DATA;
      acc_q   <= 4'd0;
      cnt_q   <= 8'd0;
      ok_q    <= 1'b0;
      syn_q   <= 4'd0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ok_q    <= ok_d;
      syn_q   <= syn_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed bench for parity_frame_checker with FRAME_LEN=4, CNT_W=2.
module tb_parity_frame_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_nibble = 4'd0;
  logic       in_ready;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic       res_ok;
  logic [3:0] res_syndrome;
  logic [1:0] err_count;
  logic       clr_err = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  parity_frame_checker #(.FRAME_LEN(4), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_nibble(in_nibble),
    .in_ready(in_ready), .res_valid(res_valid), .res_ready(res_ready),
    .res_ok(res_ok), .res_syndrome(res_syndrome), .err_count(err_count),
    .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // nibs[19:16] is data 1 ... nibs[7:4] data 4, nibs[3:0] the check nibble.
  task automatic run_frame(input string tag, input logic [19:0] nibs, input bit gaps,
                           input bit clr_on_check, input logic ok_exp,
                           input logic [3:0] syn_exp, input logic [1:0] err_exp);
    for (int i = 4; i >= 0; i--) begin
      if (gaps) begin
        in_valid = 1'b0;
        tick();
      end
      in_valid  = 1'b1;
      in_nibble = nibs[i*4 +: 4];
      clr_err   = clr_on_check && (i == 0);
      if (i == 0) chk({tag, "_rdy_chk"}, in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      clr_err  = 1'b0;
      if (i == 1) chk({tag, "_no_res_early"}, res_valid, 1'b0);
    end
    chk({tag, "_valid"}, res_valid, 1'b1);
    chk({tag, "_ok"}, res_ok, ok_exp);
    chk({tag, "_syn"}, res_syndrome, syn_exp);
    chk({tag, "_err"}, err_count, err_exp);
  endtask

  task automatic accept(input string tag);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_released"}, res_valid, 1'b0);
  endtask

  initial begin
    #2;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_ok", res_ok, 1'b0);
    chk("rst_syn", res_syndrome, 4'h0);
    chk("rst_err", err_count, 2'd0);
    tick();
    rst_n = 1'b1;
    tick();

    run_frame("good", 20'h1248F, 1'b0, 1'b0, 1'b1, 4'h0, 2'd0);
    accept("good");
    run_frame("bad", 20'h12487, 1'b0, 1'b0, 1'b0, 4'h8, 2'd1);

    // Backpressure: nibble 5 offered throughout must not be consumed.
    in_valid  = 1'b1;
    in_nibble = 4'h5;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_valid", res_valid, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_syn", res_syndrome, 4'h8);
      chk("bp_ok", res_ok, 1'b0);
    end
    in_valid = 1'b0;
    accept("bp");
    run_frame("after_bp", 20'h1248F, 1'b0, 1'b0, 1'b1, 4'h0, 2'd1);
    accept("after_bp");

    run_frame("gap_good", 20'h35AC0, 1'b1, 1'b0, 1'b1, 4'h0, 2'd1);
    accept("gap_good");
    run_frame("gap_bad", 20'h35AC2, 1'b1, 1'b0, 1'b0, 4'h2, 2'd2);
    accept("gap_bad");

    // Reset mid-frame after two nibbles.
    for (int i = 0; i < 2; i++) begin
      in_valid  = 1'b1;
      in_nibble = (i == 0) ? 4'h3 : 4'h5;
      tick();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1'b0);
    chk("midrst_err", err_count, 2'd0);
    chk("midrst_valid", res_valid, 1'b0);
    #3 rst_n = 1'b1;
    tick();
    run_frame("post_rst", 20'h1248F, 1'b0, 1'b0, 1'b1, 4'h0, 2'd0);
    accept("post_rst");

    // Saturation: five bad frames.
    for (int f = 0; f < 5; f++) begin
      run_frame("sat", 20'h12487, 1'b0, 1'b0, 1'b0, 4'h8, (f >= 2) ? 2'd3 : 2'(f + 1));
      accept("sat");
    end

    // Clear coinciding with a bad-frame increment: clear wins, FSM unaffected.
    run_frame("clr", 20'h12487, 1'b0, 1'b1, 1'b0, 4'h8, 2'd0);
    accept("clr");
    run_frame("after_clr", 20'h12486, 1'b1, 1'b0, 1'b0, 4'h9, 2'd1);
    accept("after_clr");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/parity_frame_checker.md
PARITY_FRAME_CHECKER -- requirements
Module: parity_frame_checker

Interface
REQ-001 Parameter FRAME_LEN, default 8: data nibbles per frame; legal range 2..255.
REQ-002 Parameter CNT_W, default 8: width of the error counter.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  in_nibble is valid.
REQ-007 in_nibble  input  4  data nibble or check nibble.
REQ-008 in_ready  output  1  block can accept a nibble.
REQ-009 res_valid  output  1  frame result is available.
REQ-010 res_ready  input  1  downstream accepts the result.
REQ-011 res_ok  output  1  frame passed the check.
REQ-012 res_syndrome  output  4  column-parity mismatch bits.
REQ-013 err_count  output  CNT_W  saturating count of failed frames.
REQ-014 clr_err  input  1  synchronous clear of err_count.

Function
REQ-015 A transfer SHALL occur on each rising clk edge where in_valid=1 and in_ready=1; nibbles are never taken without a transfer.
REQ-016 FSM states SHALL be S_DATA, S_CHECK and S_RESULT; the reset state SHALL be S_DATA.
REQ-017 In S_DATA, each transfer SHALL XOR in_nibble into a 4-bit accumulator acc and increment the nibble counter.
REQ-018 S_DATA SHALL go to S_CHECK on the transfer that brings the nibble counter to FRAME_LEN.
REQ-019 In S_CHECK, one transfer SHALL register res_syndrome = acc ^ in_nibble and res_ok = (acc ^ in_nibble == 0), then go to S_RESULT.
REQ-020 The result SHALL be valid exactly one cycle after the check-nibble transfer.
REQ-021 in_ready SHALL be 1 in S_DATA and S_CHECK, 0 in S_RESULT, and 0 while rst_n=0.
REQ-022 res_valid SHALL be 1 only in S_RESULT.
REQ-023 res_ok and res_syndrome SHALL stay stable while res_valid=1 and res_ready=0.
REQ-024 On the cycle with res_valid=1 and res_ready=1, the block SHALL return to S_DATA and clear acc and the nibble counter.
REQ-025 The next frame's first nibble SHALL be accepted no earlier than the cycle after the result handshake.
REQ-026 Entry to S_RESULT with a nonzero syndrome SHALL increment err_count by 1, saturating at 2^CNT_W-1.
REQ-027 clr_err=1 SHALL zero err_count at the next edge; clr_err SHALL win over a simultaneous increment.
REQ-028 clr_err SHALL NOT affect the FSM, acc or the nibble counter.
REQ-029 in_valid low inside a frame (gaps) SHALL stall the frame without losing accumulated state.

Reset
REQ-030 While rst_n=0, state SHALL be S_DATA, acc=0, counter=0, res_valid=0, res_ok=0, res_syndrome=0 and err_count=0, independent of clk.
REQ-031 Reset asserted mid-frame or in S_RESULT SHALL discard the partial frame or pending result.
REQ-032 The first transfer after rst_n deasserts SHALL be treated as data nibble 1 of a new frame.

Verification (FRAME_LEN=4, CNT_W=2 unless stated)
REQ-033 Good frame: nibbles 1,2,4,8, check F -> res_valid one cycle later, res_ok=1, syndrome=0, err_count=0.
REQ-034 Bad frame: nibbles 1,2,4,8, check 7 -> res_ok=0, syndrome=8, err_count=1.
REQ-035 Backpressure: hold res_ready=0 for 5 cycles with in_valid=1 -> res_valid stays 1, in_ready stays 0, outputs stable, no nibble consumed.
REQ-036 Gaps and reset: in_valid toggling every other cycle -> same result as gap-free input; rst_n pulsed low after 2 nibbles -> following 4 nibbles plus check form a fresh frame.
REQ-037 Saturation and clear: 5 bad frames -> err_count=3; clr_err asserted on a bad-frame result cycle -> err_count=0.
